hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and flush controller for the 5-stage MIPS32 core; the control end of the ID/EX pipeline register. Consumes ID-stage operand info and the fields already latched in ID/EX. Drives PC write-enable, IF/ID hold/flush and the ID/EX `Flush` input, resolving load-use stalls, taken branches, jumps and multi-cycle MULT/DIV occupancy. Also keeps a saturating stall-cycle counter for performance debug.

## Interface
- `MDU_LATENCY`, default 32: cycles HI/LO stay busy after a MULT/DIV issues, legal range 2..255.
- `CNT_W`, default 32: width of `StallCount`.

Ports:
- `clk`  in  1  core clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `ID_Rs`, `ID_Rt`  in  5  source register numbers of the instruction in ID.
- `ID_UseRs`, `ID_UseRt`  in  1  ID instruction actually reads rs / rt.
- `ID_Jump`  in  1  J/JAL/JR/JALR resolved in ID.
- `ID_MDUStart`  in  1  ID instruction is MULT/MULTU/DIV/DIVU.
- `ID_ReadHiLo`  in  1  ID instruction is MFHI/MFLO/MTHI/MTLO.
- `EX_MemRead`  in  1  ID/EX latched MemRead (load in EX).
- `EX_Rt`  in  5  ID/EX latched Rt (load destination).
- `EX_BranchTaken`  in  1  branch in EX resolved taken.
- `PC_Write`  out  1  PC register enable.
- `IF_ID_Write`  out  1  IF/ID register enable.
- `IF_ID_Flush`  out  1  zero the IF/ID instruction.
- `ID_EX_Flush`  out  1  drives ID/EX `Flush`; kills MemWrite/MemRead/RegWrite.
- `MDU_Busy`  out  1  HI/LO result pending.
- `StallCount`  out  CNT_W  saturating count of cycles with `PC_Write`=0.

## Operation
- Control outputs are combinational from the current inputs and the MDU state; the pipeline registers sample them on the next edge.
- Hazard conditions:
  - `LoadUse` = `EX_MemRead` & `EX_Rt`!=0 & ((`ID_UseRs` & `EX_Rt`==`ID_Rs`) | (`ID_UseRt` & `EX_Rt`==`ID_Rt`)).
  - `MduHaz` = `MDU_Busy` & (`ID_MDUStart` | `ID_ReadHiLo`).
  - `Stall` = (`LoadUse` | `MduHaz`) & !`EX_BranchTaken`.
- Priority, highest first:
  1. `EX_BranchTaken`: `IF_ID_Flush`=1, `ID_EX_Flush`=1, `PC_Write`=1, `IF_ID_Write`=1. Any stall or jump in the same cycle is ignored, because the ID instruction is squashed.
  2. `Stall`: `PC_Write`=0, `IF_ID_Write`=0, `ID_EX_Flush`=1 (bubble), `IF_ID_Flush`=0.
  3. `ID_Jump`: `IF_ID_Flush`=1; all other controls take their normal values.
  4. Otherwise `PC_Write`=`IF_ID_Write`=1 and both flushes are 0.
- MDU FSM, states IDLE / BUSY, with an 8-bit down-counter `mdu_cnt`:
  - Issue = `ID_MDUStart` & !`Stall` & !`EX_BranchTaken`. On issue, `mdu_cnt` <= `MDU_LATENCY` and the state becomes BUSY.
  - In BUSY, `mdu_cnt` decrements each cycle. When it reaches 1 and no new issue occurs, the next state is IDLE with `mdu_cnt`=0.
  - A new issue while BUSY cannot happen, because `MduHaz` stalls it.
  - `MDU_Busy` = (state==BUSY).
  - Branch flushes do not cancel an MDU op that has already issued.
- `StallCount` increments on every edge where `PC_Write`=0 and holds at all-ones.

## Timing
- Reset (asynchronous assert, released synchronously by the system): state IDLE, `mdu_cnt`=0, `StallCount`=0. With all inputs at 0, outputs are `PC_Write`=1, `IF_ID_Write`=1, `IF_ID_Flush`=0, `ID_EX_Flush`=0, `MDU_Busy`=0.
- Reset asserted mid-MDU-op aborts it: `MDU_Busy` drops immediately (asynchronously).
- Load-use costs exactly 1 stall cycle. On the next cycle the load has left EX, so `LoadUse` clears.
- `MDU_Busy` is high for exactly `MDU_LATENCY` cycles, starting at the edge that issues the op. A dependent MFHI waits until the first cycle with `MDU_Busy`=0.
- Zero latency from inputs to control outputs; one edge from issue to `MDU_Busy`.

## Structure
- Shared package `hazard_pkg`: MDU state encoding (IDLE=0, BUSY=1) and the default `MDU_LATENCY` constant.
- One natural sub-module, `mdu_tracker`: the FSM plus `mdu_cnt`; it outputs `MDU_Busy` and takes `issue` as input. Hazard priority logic and `StallCount` stay in the top level.

## Test plan
- Load in EX: `EX_MemRead`=1, `EX_Rt`=5, `ID_UseRs`=1, `ID_Rs`=5 -> one cycle of `PC_Write`=0, `IF_ID_Write`=0, `ID_EX_Flush`=1; `StallCount` 0->1.
- Same case with `EX_Rt`=0 -> no stall. Case with `ID_UseRt`=0 and `ID_Rt`=5 -> no stall.
- `EX_BranchTaken`=1 together with the load-use match -> `IF_ID_Flush`=1, `ID_EX_Flush`=1, `PC_Write`=1; `StallCount` unchanged.
- `ID_MDUStart` for 1 cycle, `MDU_LATENCY`=4, then `ID_ReadHiLo` held -> `MDU_Busy` high for 4 cycles with `PC_Write`=0 during them; MFHI proceeds on the 5th cycle.
- `ID_MDUStart` coincident with `EX_BranchTaken` -> no issue; `MDU_Busy` stays 0.
- Reset pulse while `MDU_Busy`=1 with `mdu_cnt`=10 -> `MDU_Busy`=0 and `StallCount`=0 immediately; `ID_Jump`=1 afterwards -> `IF_ID_Flush`=1 only.

Source files
------------

// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_pkg
// Purpose  : Shared types and constants for the pipeline hazard controller.
// Revision : 1.0 - initial release
// ============================================================================
package hazard_pkg;

  // HI/LO tracker state encoding
  typedef enum logic [0:0] {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

  // Default number of cycles HI/LO stay busy after a MULT/DIV issues
  localparam int unsigned MDU_LATENCY_DEFAULT = 32;

  // Width of the MDU occupancy down-counter (latency range 2..255)
  localparam int unsigned MDU_CNT_W = 8;

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/hazard_ctrl_mdu_tracker.sv
`default_nettype none
// ============================================================================
// Module   : mdu_tracker
// Purpose  : Tracks HI/LO occupancy after a MULT/DIV issue. Goes BUSY on the
//            issuing edge and stays busy for exactly MDU_LATENCY cycles.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_tracker
  import hazard_pkg::*;
#(
  parameter int unsigned MDU_LATENCY = MDU_LATENCY_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic issue_i,
  output logic busy_o
);

  localparam logic [MDU_CNT_W-1:0] c_LATENCY = MDU_CNT_W'(MDU_LATENCY);

  mdu_state_e             state_q, state_d;
  logic [MDU_CNT_W-1:0]   cnt_q, cnt_d;

  // State and occupancy counter registers; reset aborts any op in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: load on issue, count down while busy, release after count 1
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (issue_i) begin
      state_d = MDU_BUSY;
      cnt_d   = c_LATENCY;
    end else begin
      case (state_q)
        MDU_BUSY: begin
          if (cnt_q <= MDU_CNT_W'(1)) begin
            state_d = MDU_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_q - MDU_CNT_W'(1);
          end
        end
        default: begin
          state_d = MDU_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign busy_o = (state_q == MDU_BUSY);

endmodule : mdu_tracker
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Hazard and flush control for the 5-stage MIPS32 pipeline.
//            Resolves load-use stalls, taken branches, jumps and HI/LO
//            occupancy, and keeps a saturating stall-cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MDU_LATENCY = MDU_LATENCY_DEFAULT,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UseRs,
  input  logic             ID_UseRt,
  input  logic             ID_Jump,
  input  logic             ID_MDUStart,
  input  logic             ID_ReadHiLo,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_Rt,
  input  logic             EX_BranchTaken,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             MDU_Busy,
  output logic [CNT_W-1:0] StallCount
);

  logic             w_load_use;
  logic             w_mdu_haz;
  logic             w_stall;
  logic             w_issue;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Hazard detection; a taken branch squashes ID so it overrides any stall
  always_comb begin
    w_load_use = EX_MemRead && (EX_Rt != 5'd0) &&
                 ((ID_UseRs && (EX_Rt == ID_Rs)) ||
                  (ID_UseRt && (EX_Rt == ID_Rt)));
    w_mdu_haz  = MDU_Busy && (ID_MDUStart || ID_ReadHiLo);
    w_stall    = (w_load_use || w_mdu_haz) && !EX_BranchTaken;
    w_issue    = ID_MDUStart && !w_stall && !EX_BranchTaken;
  end

  // Pipeline control outputs in priority order: branch, stall, jump, normal
  always_comb begin
    PC_Write    = 1'b1;
    IF_ID_Write = 1'b1;
    IF_ID_Flush = 1'b0;
    ID_EX_Flush = 1'b0;
    if (EX_BranchTaken) begin
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
    end else if (w_stall) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Flush = 1'b1;
    end else if (ID_Jump) begin
      IF_ID_Flush = 1'b1;
    end
  end

  // HI/LO occupancy tracker
  mdu_tracker #(
    .MDU_LATENCY (MDU_LATENCY)
  ) u_mdu_tracker (
    .clk     (clk),
    .reset   (reset),
    .issue_i (w_issue),
    .busy_o  (MDU_Busy)
  );

  // Stall counter next value: count frozen-PC cycles, hold at all-ones
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!PC_Write && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // Stall counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign StallCount = stall_cnt_q;

endmodule : hazard_ctrl
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Self-checking bench for hazard_ctrl with a cycle-indexed
//            reference model of HI/LO occupancy and stall accounting.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  localparam int unsigned LAT   = 4;
  localparam int unsigned CW    = 4;
  localparam int          SCMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    ID_Rs, ID_Rt, EX_Rt;
  logic          ID_UseRs, ID_UseRt, ID_Jump, ID_MDUStart, ID_ReadHiLo;
  logic          EX_MemRead, EX_BranchTaken;
  logic          PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, MDU_Busy;
  logic [CW-1:0] StallCount;

  hazard_ctrl #(
    .MDU_LATENCY (LAT),
    .CNT_W       (CW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ID_Rs          (ID_Rs),
    .ID_Rt          (ID_Rt),
    .ID_UseRs       (ID_UseRs),
    .ID_UseRt       (ID_UseRt),
    .ID_Jump        (ID_Jump),
    .ID_MDUStart    (ID_MDUStart),
    .ID_ReadHiLo    (ID_ReadHiLo),
    .EX_MemRead     (EX_MemRead),
    .EX_Rt          (EX_Rt),
    .EX_BranchTaken (EX_BranchTaken),
    .PC_Write       (PC_Write),
    .IF_ID_Write    (IF_ID_Write),
    .IF_ID_Flush    (IF_ID_Flush),
    .ID_EX_Flush    (ID_EX_Flush),
    .MDU_Busy       (MDU_Busy),
    .StallCount     (StallCount)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: cycle index, start cycle of the last MDU op, stall tally
  int cyc        = 0;
  int busy_start = -1000;
  int m_sc       = 0;
  bit e_pcw, e_ifw, e_iff, e_idf, e_issue;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    ID_Rs = 5'd0; ID_Rt = 5'd0; EX_Rt = 5'd0;
    ID_UseRs = 1'b0; ID_UseRt = 1'b0; ID_Jump = 1'b0;
    ID_MDUStart = 1'b0; ID_ReadHiLo = 1'b0;
    EX_MemRead = 1'b0; EX_BranchTaken = 1'b0;
  endtask

  function automatic bit model_busy();
    return (cyc >= busy_start) && (cyc < busy_start + int'(LAT));
  endfunction

  // Derive expected controls from the current inputs and check all outputs
  task automatic check_now(input string tag);
    bit lu, mh, st;
    lu = EX_MemRead && (EX_Rt != 0) &&
         ((ID_UseRs && EX_Rt == ID_Rs) || (ID_UseRt && EX_Rt == ID_Rt));
    mh = model_busy() && (ID_MDUStart || ID_ReadHiLo);
    st = (lu || mh) && !EX_BranchTaken;
    if (EX_BranchTaken) begin
      e_pcw = 1; e_ifw = 1; e_iff = 1; e_idf = 1;
    end else if (st) begin
      e_pcw = 0; e_ifw = 0; e_iff = 0; e_idf = 1;
    end else begin
      e_pcw = 1; e_ifw = 1; e_iff = ID_Jump; e_idf = 0;
    end
    e_issue = ID_MDUStart && !st && !EX_BranchTaken;
    #1;
    chk({tag, ".PC_Write"},    32'(PC_Write),    32'(e_pcw));
    chk({tag, ".IF_ID_Write"}, 32'(IF_ID_Write), 32'(e_ifw));
    chk({tag, ".IF_ID_Flush"}, 32'(IF_ID_Flush), 32'(e_iff));
    chk({tag, ".ID_EX_Flush"}, 32'(ID_EX_Flush), 32'(e_idf));
    chk({tag, ".MDU_Busy"},    32'(MDU_Busy),    32'(model_busy()));
    chk({tag, ".StallCount"},  32'(StallCount),  32'(m_sc));
  endtask

  // Check the current cycle, then advance one edge and update the model
  task automatic cycle(input string tag);
    check_now(tag);
    @(posedge clk);
    cyc++;
    if (e_issue) busy_start = cyc;
    if (!e_pcw) m_sc = (m_sc == SCMAX) ? SCMAX : m_sc + 1;
    @(negedge clk);
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    @(negedge clk);
    check_now("reset");
    @(negedge clk);
    reset = 1'b0;
    cycle("idle");

    // Load-use on rs: one stall cycle, then clear
    EX_MemRead = 1; EX_Rt = 5'd5; ID_UseRs = 1; ID_Rs = 5'd5;
    cycle("loaduse_rs");
    clear_inputs();
    cycle("after_loaduse");

    // Load to $zero never stalls
    EX_MemRead = 1; EX_Rt = 5'd0; ID_UseRs = 1; ID_Rs = 5'd0;
    cycle("load_r0");
    // rt matches but is not read
    clear_inputs();
    EX_MemRead = 1; EX_Rt = 5'd5; ID_UseRt = 0; ID_Rt = 5'd5;
    cycle("rt_unused");
    ID_UseRt = 1;
    cycle("loaduse_rt");

    // Branch overrides load-use
    clear_inputs();
    EX_MemRead = 1; EX_Rt = 5'd5; ID_UseRs = 1; ID_Rs = 5'd5; EX_BranchTaken = 1;
    cycle("branch_loaduse");
    clear_inputs();
    cycle("after_branch");

    // MULT issue then dependent MFHI held until HI/LO free
    ID_MDUStart = 1;
    cycle("mdu_issue");
    clear_inputs();
    ID_ReadHiLo = 1;
    for (int i = 0; i < int'(LAT) + 1; i++) cycle("mfhi_wait");
    clear_inputs();
    cycle("mdu_done");

    // MDU start squashed by taken branch
    ID_MDUStart = 1; EX_BranchTaken = 1;
    cycle("mdu_branch");
    clear_inputs();
    cycle("mdu_not_issued");

    // Asynchronous reset mid-op
    ID_MDUStart = 1;
    cycle("mdu_issue2");
    clear_inputs();
    cycle("mdu_busy2");
    reset = 1'b1;
    busy_start = -1000;
    m_sc = 0;
    #1;
    chk("async_reset.MDU_Busy",   32'(MDU_Busy),   32'(0));
    chk("async_reset.StallCount", 32'(StallCount), 32'(0));
    @(posedge clk);
    cyc++;
    @(negedge clk);
    reset = 1'b0;
    ID_Jump = 1;
    cycle("jump_after_reset");
    clear_inputs();

    // Randomized traffic with biased register numbers to provoke matches
    for (int n = 0; n < 400; n++) begin
      ID_Rs          = 5'($urandom_range(0, 3));
      ID_Rt          = 5'($urandom_range(0, 3));
      EX_Rt          = 5'($urandom_range(0, 3));
      ID_UseRs       = 1'($urandom_range(0, 1));
      ID_UseRt       = 1'($urandom_range(0, 1));
      EX_MemRead     = 1'($urandom_range(0, 1));
      ID_Jump        = ($urandom_range(0, 7) == 0);
      EX_BranchTaken = ($urandom_range(0, 7) == 0);
      ID_MDUStart    = ($urandom_range(0, 5) == 0);
      ID_ReadHiLo    = ($urandom_range(0, 3) == 0);
      cycle("random");
    end
    clear_inputs();
    cycle("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_hazard_ctrl
`default_nettype wire
